// File: rtl/riscv_dbus_resp.sv
// Single-outstanding RV64 data-bus responder backed by a byte-lane-writable dword store.
// Optional macro RISCV_DBUS_MISALIGN_TRAP_EN faults misaligned accesses instead of aligning them.
module riscv_dbus_resp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sft_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << (ADDR_WIDTH - 3);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                  state;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic [ADDR_WIDTH-4:0]   idx;
    logic [2:0]              size_mask;
    logic [2:0]              offset;
    logic                    misaligned;
    logic [NUM_LANES-1:0]    lane_base;
    logic [NUM_LANES-1:0]    lane_en;
    logic [DATA_WIDTH-1:0]   wdata_sh;
    logic [DATA_WIDTH-1:0]   rd_sh;
    logic [DATA_WIDTH-1:0]   load_data;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        accept     = req_valid && req_ready;
        idx        = req_addr[ADDR_WIDTH-1:3];
        size_mask  = 3'b000;
        lane_base  = '0;
        case (req_size)
            2'd0: begin size_mask = 3'b000; lane_base = NUM_LANES'(1);  end
            2'd1: begin size_mask = 3'b001; lane_base = NUM_LANES'(3);  end
            2'd2: begin size_mask = 3'b011; lane_base = NUM_LANES'(15); end
            default: begin size_mask = 3'b111; lane_base = '1; end
        endcase
`ifdef RISCV_DBUS_MISALIGN_TRAP_EN
        offset     = req_addr[2:0];
        misaligned = |(req_addr[2:0] & size_mask);
`else
        offset     = req_addr[2:0] & ~size_mask;
        misaligned = 1'b0;
`endif
        lane_en    = lane_base << offset;
        wdata_sh   = req_wdata << {offset, 3'b000};
        rd_sh      = mem[idx] >> {offset, 3'b000};

        // Extension of the right-aligned lane; a dword load ignores req_unsigned.
        load_data  = rd_sh;
        case (req_size)
            2'd0: load_data = req_unsigned ? {{(DATA_WIDTH-8){1'b0}}, rd_sh[7:0]}
                                           : {{(DATA_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
            2'd1: load_data = req_unsigned ? {{(DATA_WIDTH-16){1'b0}}, rd_sh[15:0]}
                                           : {{(DATA_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
            2'd2: load_data = req_unsigned ? {{(DATA_WIDTH-32){1'b0}}, rd_sh[31:0]}
                                           : {{(DATA_WIDTH-32){rd_sh[31]}}, rd_sh[31:0]};
            default: load_data = rd_sh;
        endcase
    end

    // NOTE: storage has no reset; its contents must survive both resets and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && req_we && !misaligned && !sft_rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err_q     <= 1'b0;
        end else if (sft_rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        req_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (req_we || misaligned) ? '0 : load_data;
                        err_q     <= misaligned;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        err_q     <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Without the trap macro misaligned is tied low, so err_q never leaves 0.
    assign rsp_err = err_q;

endmodule

// File: tb/tb_riscv_dbus_resp.sv
// Scoreboard bench for riscv_dbus_resp: expected responses are queued at issue and popped on delivery.
module tb_riscv_dbus_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sft_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [16:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    riscv_dbus_resp #(.DATA_WIDTH(64), .ADDR_WIDTH(17)) dut (
        .clk(clk), .rst_n(rst_n), .sft_rst(sft_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; the response must appear right after the accepting edge.
    task automatic issue(input bit we, input logic [16:0] addr, input logic [1:0] size,
                         input bit uns, input logic [63:0] wd,
                         input logic [63:0] erd, input bit eerr);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        sb.push_back('{rdata: erd, err: eerr});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rsp_valid_latency", {63'd0, rsp_valid}, 64'd1);
        check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, e.err});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_idle_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic access(input string tag, input bit we, input logic [16:0] addr,
                          input logic [1:0] size, input bit uns, input logic [63:0] wd,
                          input logic [63:0] erd, input bit eerr);
        issue(we, addr, size, uns, wd, erd, eerr);
        collect(tag);
    endtask

    initial begin
        exp_t dropped;
        logic [63:0] mis_word;
        logic [63:0] mis_dword;
        bit          mis_err;

`ifdef RISCV_DBUS_MISALIGN_TRAP_EN
        mis_word  = 64'h0;
        mis_dword = 64'h0123456789ABCDEF;
        mis_err   = 1'b1;
`else
        mis_word  = 64'h0000000089ABCDEF;
        mis_dword = 64'h0123BEEF89ABCDEF;
        mis_err   = 1'b0;
`endif

        #12;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Dword round trip
        access("st_d10", 1, 17'h10, 2'd3, 0, 64'h8877665544332211, 64'h0, 0);
        access("ld_d10", 0, 17'h10, 2'd3, 0, 64'h0, 64'h8877665544332211, 0);

        // Byte store into lane 3, then signed/unsigned byte loads and lane isolation
        access("st_b13", 1, 17'h13, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 0);
        access("ld_bs13", 0, 17'h13, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFFF0, 0);
        access("ld_bu13", 0, 17'h13, 2'd0, 1, 64'h0, 64'h00000000000000F0, 0);
        access("ld_d10b", 0, 17'h10, 2'd3, 0, 64'h0, 64'h88776655F0332211, 0);
        access("ld_hs12", 0, 17'h12, 2'd1, 0, 64'h0, 64'hFFFFFFFFFFFFF033, 0);
        access("ld_wu14", 0, 17'h14, 2'd2, 1, 64'h0, 64'h0000000088776655, 0);
        access("ld_ws14", 0, 17'h14, 2'd2, 0, 64'h0, 64'hFFFFFFFF88776655, 0);
        access("ld_dhi", 1, 17'h1FFF8, 2'd3, 0, 64'hCAFEF00DDEADBEEF, 64'h0, 0);
        access("ld_dhi_rd", 0, 17'h1FFF8, 2'd3, 1, 64'h0, 64'hCAFEF00DDEADBEEF, 0);

        // Misalignment: fault with the macro, silent alignment without
        access("st_d00", 1, 17'h0, 2'd3, 0, 64'h0123456789ABCDEF, 64'h0, 0);
        access("ld_w02", 0, 17'h2, 2'd2, 1, 64'h0, mis_word, mis_err);
        access("st_h05", 1, 17'h5, 2'd1, 0, 64'h000000000000BEEF, 64'h0, mis_err);
        access("ld_d00", 0, 17'h0, 2'd3, 0, 64'h0, mis_dword, 0);

        // Back-pressure: response held 5 cycles, a second request is ignored
        issue(0, 17'h10, 2'd3, 0, 64'h0, 64'h88776655F0332211, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h10; req_size = 2'd3;
        req_wdata = 64'h5555555555555555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_rdata", rsp_rdata, 64'h88776655F0332211);
            check("stall_ready", {63'd0, req_ready}, 64'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        collect("stall");
        access("ld_after_stall", 0, 17'h10, 2'd3, 0, 64'h0, 64'h88776655F0332211, 0);

        // Asynchronous reset while a response is pending
        issue(0, 17'h10, 2'd3, 0, 64'h0, 64'h88776655F0332211, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, rsp_valid}, 64'd0);
        check("arst_ready", {63'd0, req_ready}, 64'd1);
        check("arst_rdata", rsp_rdata, 64'd0);
        dropped = sb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        access("ld_after_arst", 0, 17'h10, 2'd3, 0, 64'h0, 64'h88776655F0332211, 0);

        // Synchronous reset for one edge while in RESP
        issue(0, 17'h13, 2'd0, 1, 64'h0, 64'h00000000000000F0, 0);
        @(negedge clk);
        sft_rst = 1'b1;
        @(posedge clk);
        #1;
        sft_rst = 1'b0;
        check("srst_valid", {63'd0, rsp_valid}, 64'd0);
        check("srst_ready", {63'd0, req_ready}, 64'd1);
        dropped = sb.pop_front();
        @(posedge clk);
        #1;
        check("srst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        access("ld_after_srst", 0, 17'h13, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFFF0, 0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_dbus_resp.md
RISCV_DBUS_RESP -- requirements
Module: riscv_dbus_resp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64; data bus width, fixed at 64 for RV64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 17; byte address width, 128 KiB backing store.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port sft_rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port req_valid  input  1  core presents a request.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  core consumes the response.
REQ-015 SHALL have port rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  access fault flag.

Function
REQ-017 SHALL hold a storage array of 2^(ADDR_WIDTH-3) dwords, indexed by req_addr[ADDR_WIDTH-1:3], little-endian byte lanes.
REQ-018 SHALL implement a two-state FSM: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-019 SHALL accept a request on a cycle N edge where req_valid and req_ready are both 1, then move IDLE->RESP.
REQ-020 SHALL, on accept, write only the addressed byte lanes of a store from req_wdata low bytes; other lanes are unchanged.
REQ-021 SHALL, on accept, read the addressed dword synchronously and register the selected, extended load result, so rsp_valid=1 and rsp_rdata are valid from cycle N+1.
REQ-022 SHALL keep rsp_rdata and rsp_err stable while in RESP with rsp_ready=0.
REQ-023 SHALL move RESP->IDLE on an edge where rsp_ready=1; a new request is accepted no earlier than the following edge, giving a maximum throughput of one access per 2 cycles.
REQ-024 SHALL ignore req_* fields while in RESP; no request is queued.
REQ-025 SHALL select the load lane by req_addr[2:0], and extend it to 64 bits per req_size and req_unsigned; a dword load ignores req_unsigned.
REQ-026 SHALL drive rsp_rdata to 0 for every store response.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronous) or on a clock edge with sft_rst=1, force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-028 SHALL discard any pending response on reset in RESP; a store already committed at accept is not rolled back.
REQ-029 SHALL NOT clear storage contents on either reset.

Configuration
REQ-030 SHALL, with RISCV_DBUS_MISALIGN_TRAP_EN defined, treat an access whose address is not a multiple of its size as a fault: no storage write, rsp_err=1, rsp_rdata=0, with normal handshake timing.
REQ-031 SHALL, without RISCV_DBUS_MISALIGN_TRAP_EN, force the low address bits to 0 to align each access to its size, and hold rsp_err at constant 0.

Verification
REQ-032 SHALL cover: store dword 0x8877665544332211 to addr 0x10, then load dword from 0x10 -> rsp_rdata=0x8877665544332211, rsp_err=0, rsp_valid exactly 1 cycle after each accept.
REQ-033 SHALL cover: store byte 0xF0 to addr 0x13, then load byte signed from 0x13 -> 0xFFFFFFFFFFFFFFF0; load byte unsigned -> 0x00000000000000F0; a dword load from 0x10 shows only lane 3 changed.
REQ-034 SHALL cover: load issued with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is ignored; rsp_ready=1 -> IDLE on the next edge.
REQ-035 SHALL cover: with the macro defined, load word from addr 0x2 -> rsp_err=1, rsp_rdata=0; without it -> word at 0x0 returned, rsp_err=0.
REQ-036 SHALL cover: rst_n pulsed low mid-cycle while in RESP -> rsp_valid=0 and req_ready=1 immediately; previously stored data at 0x10 still reads back correctly after reset.
REQ-037 SHALL cover: sft_rst=1 for one edge while in RESP -> IDLE after that edge, no response delivered.
